// File: rtl/sample_accum_pkg.sv
// rtl/sample_accum_pkg.sv - shared defaults, derived widths and FSM state type for sample_accum
//
// Purpose: default sample width and block-length exponent, the derived
//          accumulator width, and the two-state controller enum.
// Ports:   none (package).
package sample_accum_pkg;

  localparam int DW_DEF    = 4;
  localparam int LOG2N_DEF = 3;
  localparam int SUM_W     = DW_DEF + LOG2N_DEF;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

endpackage

// File: rtl/sample_ctr.sv
// rtl/sample_ctr.sv - per-block sample counter with terminal-count flag
//
// Purpose: counts accepted samples within a block of 2**LOG2N, wrapping to 0
//          after the last one, and flags when the count is at N-1.
// Ports:   clk   - clock
//          res   - asynchronous active-high reset
//          clr   - synchronous clear (wins over inc)
//          inc   - advance the count by one
//          cnt   - current count (samples accepted in this block)
//          last  - cnt == N-1
module sample_ctr #(
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             inc,
  output logic [LOG2N-1:0] cnt,
  output logic             last
);

  logic [LOG2N-1:0] cnt_d, cnt_q;

  // Natural LOG2N-bit wrap takes N-1 back to 0 when the block completes.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + LOG2N'(1);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = &cnt_q;

endmodule

// File: rtl/sample_accum.sv
// rtl/sample_accum.sv - block accumulator producing sum and mean of every 2**LOG2N samples
//
// Purpose: accumulates accepted samples; on the Nth sample publishes the block
//          sum and truncated mean and pulses out_vld for one cycle.
// Option:  SAMPLE_ACCUM_PEAK_EN adds per-block max_out/min_out outputs.
// Ports:   clk      - clock
//          res      - asynchronous active-high reset
//          samp_in  - sample value (DW)
//          samp_vld - sample strobe, one sample per high cycle
//          clr      - synchronous abort of the partial block
//          sum_out  - sum of last completed block (DW+LOG2N)
//          avg_out  - sum_out >> LOG2N (DW)
//          out_vld  - one-cycle pulse with each new result
//          samp_cnt - samples accepted in the current block (LOG2N)
//          max_out  - block maximum (DW, SAMPLE_ACCUM_PEAK_EN only)
//          min_out  - block minimum (DW, SAMPLE_ACCUM_PEAK_EN only)
module sample_accum
  import sample_accum_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic                clk,
  input  logic                res,
  input  logic [DW-1:0]       samp_in,
  input  logic                samp_vld,
  input  logic                clr,
  output logic [DW+LOG2N-1:0] sum_out,
  output logic [DW-1:0]       avg_out,
  output logic                out_vld,
`ifdef SAMPLE_ACCUM_PEAK_EN
  output logic [DW-1:0]       max_out,
  output logic [DW-1:0]       min_out,
`endif
  output logic [LOG2N-1:0]    samp_cnt
);

  localparam int SW = DW + LOG2N;

  state_e          state_d, state_q;
  logic [SW-1:0]   acc_d, acc_q;
  logic [SW-1:0]   sum_d, sum_q;
  logic [DW-1:0]   avg_d, avg_q;
  logic [SW-1:0]   sum_next;
  logic            accept;
  logic            last;
  logic            blk_done;

  // clr drops a concurrent sample, so it never counts toward the block.
  assign accept   = samp_vld & ~clr;
  assign blk_done = accept & last;
  assign sum_next = acc_q + SW'(samp_in);

  sample_ctr #(
    .LOG2N (LOG2N)
  ) u_ctr (
    .clk  (clk),
    .res  (res),
    .clr  (clr),
    .inc  (accept),
    .cnt  (samp_cnt),
    .last (last)
  );

  // DONE only marks the result cycle; samples keep flowing through it,
  // so the datapath below does not look at the state at all.
  always_comb begin
    state_d = ACC;
    if (!clr && blk_done) begin
      state_d = DONE;
    end
  end

  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    avg_d = avg_q;
    if (clr) begin
      acc_d = '0;
    end else if (accept) begin
      if (last) begin
        sum_d = sum_next;
        avg_d = DW'(sum_next >> LOG2N);
        acc_d = '0;
      end else begin
        acc_d = sum_next;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= ACC;
      acc_q   <= '0;
      sum_q   <= '0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      avg_q   <= avg_d;
    end
  end

  assign sum_out = sum_q;
  assign avg_out = avg_q;
  assign out_vld = (state_q == DONE);

`ifdef SAMPLE_ACCUM_PEAK_EN
  // Running extremes restart at 0 / all-ones so the first sample of a
  // block always replaces them without needing a first-sample flag.
  logic [DW-1:0] run_max_d, run_max_q;
  logic [DW-1:0] run_min_d, run_min_q;
  logic [DW-1:0] max_d, max_q;
  logic [DW-1:0] min_d, min_q;
  logic [DW-1:0] cur_max, cur_min;

  assign cur_max = (samp_in > run_max_q) ? samp_in : run_max_q;
  assign cur_min = (samp_in < run_min_q) ? samp_in : run_min_q;

  always_comb begin
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    max_d     = max_q;
    min_d     = min_q;
    if (clr) begin
      run_max_d = '0;
      run_min_d = '1;
    end else if (accept) begin
      if (last) begin
        max_d     = cur_max;
        min_d     = cur_min;
        run_max_d = '0;
        run_min_d = '1;
      end else begin
        run_max_d = cur_max;
        run_min_d = cur_min;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      run_max_q <= '0;
      run_min_q <= '1;
      max_q     <= '0;
      min_q     <= '1;
    end else begin
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      max_q     <= max_d;
      min_q     <= min_d;
    end
  end

  assign max_out = max_q;
  assign min_out = min_q;
`endif

endmodule

// File: tb/tb_sample_accum.sv
// tb/tb_sample_accum.sv - directed self-checking bench for sample_accum
module tb_sample_accum;

  logic       clk = 1'b0;
  logic       res;
  logic [3:0] samp_in;
  logic       samp_vld;
  logic       clr;
  logic [6:0] sum_out;
  logic [3:0] avg_out;
  logic       out_vld;
  logic [2:0] samp_cnt;
`ifdef SAMPLE_ACCUM_PEAK_EN
  logic [3:0] max_out;
  logic [3:0] min_out;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sample_accum dut (
    .clk      (clk),
    .res      (res),
    .samp_in  (samp_in),
    .samp_vld (samp_vld),
    .clr      (clr),
    .sum_out  (sum_out),
    .avg_out  (avg_out),
    .out_vld  (out_vld),
`ifdef SAMPLE_ACCUM_PEAK_EN
    .max_out  (max_out),
    .min_out  (min_out),
`endif
    .samp_cnt (samp_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] v);
    samp_in  = v;
    samp_vld = 1'b1;
    tick();
    samp_vld = 1'b0;
  endtask

  int pulse_at[$];

  initial begin
    res = 1'b1; samp_in = '0; samp_vld = 1'b0; clr = 1'b0;
    #12;
    check_eq("rst_sum", 32'(sum_out), 0);
    check_eq("rst_avg", 32'(avg_out), 0);
    check_eq("rst_vld", 32'(out_vld), 0);
    check_eq("rst_cnt", 32'(samp_cnt), 0);
`ifdef SAMPLE_ACCUM_PEAK_EN
    check_eq("rst_max", 32'(max_out), 0);
    check_eq("rst_min", 32'(min_out), 32'hF);
`endif
    @(negedge clk);
    res = 1'b0;
    tick();

    // Full-scale block: 8 x F.
    for (int i = 0; i < 8; i++) begin
      put(4'hF);
      if (i < 7) check_eq("ff_novld", 32'(out_vld), 0);
    end
    check_eq("ff_sum", 32'(sum_out), 32'h78);
    check_eq("ff_avg", 32'(avg_out), 32'hF);
    check_eq("ff_vld", 32'(out_vld), 1);
    check_eq("ff_cnt_wrap", 32'(samp_cnt), 0);
    tick();
    check_eq("ff_vld_one", 32'(out_vld), 0);
    check_eq("ff_sum_hold", 32'(sum_out), 32'h78);

    // Sparse ramp 0..7, one valid every 8 cycles.
    for (int i = 0; i < 8; i++) begin
      put(4'(i));
      check_eq("ramp_cnt", 32'(samp_cnt), 32'((i + 1) % 8));
      if (i < 7) begin
        check_eq("ramp_novld", 32'(out_vld), 0);
        check_eq("ramp_hold", 32'(sum_out), 32'h78);
      end else begin
        check_eq("ramp_vld", 32'(out_vld), 1);
      end
      for (int k = 0; k < 7; k++) tick();
      check_eq("ramp_idle_cnt", 32'(samp_cnt), 32'((i + 1) % 8));
    end
    check_eq("ramp_sum", 32'(sum_out), 28);
    check_eq("ramp_avg", 32'(avg_out), 3);

    // Reset mid-block discards the partial block.
    for (int i = 0; i < 5; i++) put(4'h9);
    check_eq("mid_cnt", 32'(samp_cnt), 5);
    #2; res = 1'b1; #2;
    check_eq("async_sum", 32'(sum_out), 0);
    check_eq("async_cnt", 32'(samp_cnt), 0);
    res = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      put(4'h2);
      if (i < 7) check_eq("post_rst_novld", 32'(out_vld), 0);
    end
    check_eq("post_rst_vld", 32'(out_vld), 1);
    check_eq("post_rst_sum", 32'(sum_out), 16);
    check_eq("post_rst_avg", 32'(avg_out), 2);

    // clr together with sample 4 drops it and the partial block.
    for (int i = 0; i < 3; i++) put(4'h5);
    clr = 1'b1; put(4'h5); clr = 1'b0;
    check_eq("clr_cnt", 32'(samp_cnt), 0);
    check_eq("clr_hold", 32'(sum_out), 16);
    for (int i = 0; i < 8; i++) begin
      put(4'h1);
      if (i < 7) check_eq("clr_prev_hold", 32'(sum_out), 16);
    end
    check_eq("clr_sum", 32'(sum_out), 8);
    check_eq("clr_avg", 32'(avg_out), 1);
    check_eq("clr_vld", 32'(out_vld), 1);

    // clr on what would be the 8th sample: no result, no pulse.
    for (int i = 0; i < 7; i++) put(4'h3);
    clr = 1'b1; put(4'h3); clr = 1'b0;
    check_eq("clr_last_novld", 32'(out_vld), 0);
    check_eq("clr_last_sum", 32'(sum_out), 8);
    check_eq("clr_last_cnt", 32'(samp_cnt), 0);

    // Back-to-back blocks, no dead cycle through DONE.
    for (int i = 0; i < 16; i++) begin
      put(4'h4);
      if (out_vld) begin
        pulse_at.push_back(i);
        check_eq("b2b_sum", 32'(sum_out), 32);
      end
    end
    tick();
    check_eq("b2b_pulses", 32'(pulse_at.size()), 2);
    if (pulse_at.size() == 2) begin
      check_eq("b2b_gap", 32'(pulse_at[1] - pulse_at[0]), 8);
      check_eq("b2b_first", 32'(pulse_at[0]), 7);
    end
    check_eq("b2b_cnt", 32'(samp_cnt), 0);

`ifdef SAMPLE_ACCUM_PEAK_EN
    begin
      logic [3:0] pk [8] = '{4'd3, 4'd9, 4'd1, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
      for (int i = 0; i < 8; i++) begin
        put(pk[i]);
        if (i < 7) check_eq("pk_max_hold", 32'(max_out), 4);
      end
      check_eq("pk_sum", 32'(sum_out), 38);
      check_eq("pk_max", 32'(max_out), 9);
      check_eq("pk_min", 32'(min_out), 1);
      check_eq("pk_vld", 32'(out_vld), 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_accum.md
SAMPLE_ACCUM -- requirements
Module: sample_accum

Interface
REQ-001 Parameter DW, default 4, sample width in bits.
REQ-002 Parameter LOG2N, default 3, log2 of samples per block (block length N = 2**LOG2N = 8).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 res  input  1  asynchronous, active-high reset.
REQ-005 samp_in  input  DW  sample value, sampled only when samp_vld=1.
REQ-006 samp_vld  input  1  sample strobe; one sample is accepted per cycle it is high.
REQ-007 clr  input  1  synchronous block abort; discards the partial accumulation.
REQ-008 sum_out  output  DW+LOG2N  registered sum of the last completed block.
REQ-009 avg_out  output  DW  registered mean of the last completed block (sum_out >> LOG2N).
REQ-010 out_vld  output  1  one-cycle pulse marking new sum_out/avg_out values.
REQ-011 samp_cnt  output  LOG2N  number of samples accepted in the current block.

Function
REQ-012 The block shall accumulate accepted samples into an internal acc register of width DW+LOG2N, which shall never overflow (max N*(2**DW-1)).
REQ-013 The FSM shall have two states. ACC is entered from reset. DONE is entered for exactly one cycle after the Nth sample, then returns to ACC.
REQ-014 In ACC, when samp_vld=1 and samp_cnt<N-1, acc shall be updated to acc+samp_in and samp_cnt shall increment.
REQ-015 In ACC, when samp_vld=1 and samp_cnt=N-1, the following shall happen on the same edge:
- sum_out <= acc+samp_in;
- avg_out <= (acc+samp_in)>>LOG2N (truncating);
- acc <= 0;
- samp_cnt <= 0 (wrap);
- FSM -> DONE.
REQ-016 out_vld shall be 1 exactly in the DONE cycle, i.e. one cycle of latency after the edge that accepts the Nth sample.
REQ-017 A sample with samp_vld=1 during DONE shall be accepted as sample 0 of the next block; there shall be no dead cycle.
REQ-018 Cycles with samp_vld=0 shall leave acc, samp_cnt, sum_out and avg_out unchanged.
REQ-019 clr=1 shall zero acc and samp_cnt and force ACC; clr has priority over samp_vld (the concurrent sample is dropped).
REQ-020 clr shall not alter sum_out or avg_out; it shall suppress a pending out_vld only if the block had not completed.
REQ-021 sum_out and avg_out shall hold their values until the next block completes.

Reset
REQ-022 While res=1, the following shall be held regardless of clk:
- acc=0, samp_cnt=0;
- sum_out=0, avg_out=0, out_vld=0;
- FSM=ACC;
- max_out=0 and min_out=all-ones, when REQ-024 applies.
REQ-023 Reset asserted mid-block shall discard the partial block; the first N accepted samples after deassertion shall form a fresh block.

Configuration
REQ-024 With macro SAMPLE_ACCUM_PEAK_EN defined, the block shall add ports max_out (output, DW) and min_out (output, DW). They shall carry the per-block maximum and minimum and shall update together with sum_out.
REQ-025 Without SAMPLE_ACCUM_PEAK_EN, those ports and their tracking registers shall not exist; the remaining behaviour shall be identical.

Structure
REQ-026 Package sample_accum_pkg shall hold the default DW and LOG2N, the derived SUM_W = DW+LOG2N, and the FSM state enum {ACC, DONE}.
REQ-027 The sample counter and its terminal-count detection shall be one sub-module, sample_ctr, providing samp_cnt and a last flag (samp_cnt=N-1).

Verification
REQ-028 Eight consecutive samp_vld cycles with samp_in=4'hF -> one cycle later: sum_out=7'h78, avg_out=4'hF, out_vld high for exactly 1 cycle.
REQ-029 Samples 0,1,2,3,4,5,6,7, each separated by 7 idle cycles (one valid every 8 cycles) -> sum_out=28, avg_out=3; samp_cnt steps 0..7 then wraps to 0.
REQ-030 res pulsed after 5 samples of 4'h9, then 8 samples of 4'h2 -> sum_out=16, avg_out=2; no out_vld before the 8th post-reset sample.
REQ-031 clr and samp_vld both high on sample 4, then 8 further samples of 4'h1 -> sum_out=8; the previous sum_out is held until then.
REQ-032 Back-to-back blocks (16 continuous samples of 4'h4) -> two out_vld pulses exactly 8 cycles apart, both with sum_out=32.
REQ-033 With SAMPLE_ACCUM_PEAK_EN, block 3,9,1,5,5,5,5,5 -> max_out=9, min_out=1, updated in the same cycle as sum_out=38.
